filter_mem_node_param: RTL

//  Clocked, parametrised filter memory node for the NoC convolution array. Captures NUM_CH filters of

---
 rtl/filter_mem_node_param_pkg.sv | 46 ++++
 rtl/filter_mem_node_param_route_hdr.sv | 45 ++++
 rtl/filter_mem_node_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/filter_mem_node_param_pkg.sv
// ---------------------------------------------------------------------------
// filter_mem_node_param_pkg
// Shared definitions for the filter memory node and its route-header helper:
// packet header field offsets (relative to the top of the payload), field
// widths, the node FSM state type and the node-id to mesh-coordinate mapping.
// ---------------------------------------------------------------------------
package filter_mem_node_param_pkg;

  // Header occupies 17 bits above the payload; bit 16 is reserved (always 0).
  localparam int HDR_W    = 17;
  localparam int ROUTE_W  = 16;
  localparam int NODE_W   = 4;
  localparam int HOP_W    = 3;

  localparam int YHOP_OFF = 0;
  localparam int YDIR_OFF = 3;
  localparam int XHOP_OFF = 4;
  localparam int XDIR_OFF = 7;
  localparam int DEST_OFF = 8;
  localparam int SRC_OFF  = 12;
  localparam int RSV_OFF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_SEND,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } nodeXy_t;

  // Node ids are 1-based; the mesh is filled row by row, meshX nodes per row.
  function automatic nodeXy_t node_to_xy(input logic [NODE_W-1:0] node, input int meshX);
    nodeXy_t xy;
    int      idx;
    idx  = int'(node) - 1;
    xy.x = 4'(idx % meshX);
    xy.y = 4'(idx / meshX);
    return xy;
  endfunction

endpackage

// File: rtl/filter_mem_node_param_route_hdr.sv
// ---------------------------------------------------------------------------
// filter_mem_node_param_route_hdr
// Combinational XY-route header builder, shared by the memory nodes.
// Ports:
//   i_src   in  4   source node id (1-based)
//   i_dest  in  4   destination node id (1-based)
//   o_hdr   out 16  {src, dest, xdir, |dx|, ydir, |dy|}
// ---------------------------------------------------------------------------
module filter_mem_node_param_route_hdr
  import filter_mem_node_param_pkg::*;
#(
  parameter int MESH_X = 5
) (
  input  logic [NODE_W-1:0]  i_src,
  input  logic [NODE_W-1:0]  i_dest,
  output logic [ROUTE_W-1:0] o_hdr
);

  nodeXy_t          w_srcXy;
  nodeXy_t          w_destXy;
  logic             w_xDir;
  logic             w_yDir;
  logic [HOP_W-1:0] w_xHop;
  logic [HOP_W-1:0] w_yHop;

  // Direction bit set means the destination lies at a larger coordinate;
  // the hop counts are magnitudes, so the subtraction order follows the direction.
  always_comb begin
    w_srcXy  = node_to_xy(i_src, MESH_X);
    w_destXy = node_to_xy(i_dest, MESH_X);
    w_xDir   = w_destXy.x > w_srcXy.x;
    w_yDir   = w_destXy.y > w_srcXy.y;
    w_xHop   = w_xDir ? HOP_W'(w_destXy.x - w_srcXy.x) : HOP_W'(w_srcXy.x - w_destXy.x);
    w_yHop   = w_yDir ? HOP_W'(w_destXy.y - w_srcXy.y) : HOP_W'(w_srcXy.y - w_destXy.y);

    o_hdr                          = '0;
    o_hdr[SRC_OFF +: NODE_W]       = i_src;
    o_hdr[DEST_OFF +: NODE_W]      = i_dest;
    o_hdr[XDIR_OFF]                = w_xDir;
    o_hdr[XHOP_OFF +: HOP_W]       = w_xHop;
    o_hdr[YDIR_OFF]                = w_yDir;
    o_hdr[YHOP_OFF +: HOP_W]       = w_yHop;
  end

endmodule

// File: rtl/filter_mem_node_param.sv
// ---------------------------------------------------------------------------
// filter_mem_node_param
// Filter memory node for the NoC convolution array. Captures NUM_CH filters of
// DEPTH_F x DEPTH_F elements, then sends each filter row as one packet with an
// XY-route header to the local router, optionally separated by GAP_CYCLES idle
// cycles. Stored filters can be replayed with i_resend without reloading.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_load_start    pulse, start a load (IDLE only)
//   i_wr_valid      load word valid; o_wr_ready high while loading
//   i_wr_addr       ch*DEPTH_F^2 + row*DEPTH_F + col
//   i_wr_data       element value
//   i_load_done     pulse, release streaming (WAIT_DONE only)
//   i_resend        pulse, replay stored rows (IDLE and loaded only)
//   o_pkt_valid / i_pkt_ready / o_pkt_data   packet stream to router
//   o_busy          high outside IDLE
//   o_addr_err      sticky out-of-range load address flag
// ---------------------------------------------------------------------------
module filter_mem_node_param
  import filter_mem_node_param_pkg::*;
#(
  parameter int DEPTH_F    = 5,
  parameter int NUM_CH     = 1,
  parameter int WIDTH_data = 8,
  parameter int WIDTH_addr = 12,
  parameter int NODE       = 11,
  parameter int PE_BASE    = 1,
  parameter int MESH_X     = 5,
  parameter int GAP_CYCLES = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_load_start,
  input  logic                                 i_wr_valid,
  output logic                                 o_wr_ready,
  input  logic [WIDTH_addr-1:0]                i_wr_addr,
  input  logic [WIDTH_data-1:0]                i_wr_data,
  input  logic                                 i_load_done,
  input  logic                                 i_resend,
  output logic                                 o_pkt_valid,
  input  logic                                 i_pkt_ready,
  output logic [DEPTH_F*WIDTH_data+HDR_W-1:0]  o_pkt_data,
  output logic                                 o_busy,
  output logic                                 o_addr_err
);

  localparam int WIDTH_payload = DEPTH_F * WIDTH_data;
  localparam int WIDTH_packet  = WIDTH_payload + HDR_W;
  localparam int ROWS          = NUM_CH * DEPTH_F;
  localparam int NUM_WORDS     = ROWS * DEPTH_F;
  localparam int ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W         = $clog2(NUM_WORDS + 1);
  localparam int GAP_W         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Destination and source ids must fit the 4-bit header fields.
  generate
    if ((PE_BASE + NUM_CH * DEPTH_F - 1 > 15) || (NODE > 15) || (MESH_X > 8)) begin : g_badParams
      $error("filter_mem_node_param: node id or mesh width out of range");
    end
  endgenerate

  state_t                   r_state;
  state_t                   w_nextState;
  logic [CNT_W-1:0]         r_loadCnt;
  logic [ROW_W-1:0]         r_sendRow;
  logic [ROW_W-1:0]         w_rowSel;
  logic [GAP_W-1:0]         r_gapCnt;
  logic                     r_loaded;
  logic                     r_addrErr;
  logic                     r_pktValid;
  logic [WIDTH_packet-1:0]  r_pktData;
  logic [WIDTH_packet-1:0]  w_pktNext;
  logic [WIDTH_payload-1:0] r_mem [ROWS];

  logic                     w_wrFire;
  logic                     w_pktFire;
  logic                     w_lastWord;
  logic                     w_lastRow;
  logic                     w_gapDone;
  logic                     w_loadPkt;
  logic                     w_addrOk;
  int                       w_addrInt;
  int                       w_rowLin;
  int                       w_col;
  logic [NODE_W-1:0]        w_dest;
  logic [ROUTE_W-1:0]       w_route;

  // Handshake qualifiers and load address decode. Each row of r_mem holds one
  // complete filter row, so the linear row index is simply addr / DEPTH_F.
  always_comb begin
    w_wrFire   = (r_state == ST_LOAD) && i_wr_valid;
    w_pktFire  = r_pktValid && i_pkt_ready;
    w_lastWord = r_loadCnt == CNT_W'(NUM_WORDS - 1);
    w_lastRow  = r_sendRow == ROW_W'(ROWS - 1);
    w_gapDone  = int'(r_gapCnt) == GAP_CYCLES - 1;
    w_addrInt  = int'(i_wr_addr);
    w_addrOk   = w_addrInt < NUM_WORDS;
    w_rowLin   = w_addrInt / DEPTH_F;
    w_col      = w_addrInt % DEPTH_F;
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_start) begin
          w_nextState = ST_LOAD;
        end else if (i_resend && r_loaded) begin
          w_nextState = ST_SEND;
        end
      end
      ST_LOAD: begin
        if (w_wrFire && w_lastWord) begin
          w_nextState = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_load_done) begin
          w_nextState = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_pktFire) begin
          if (w_lastRow) begin
            w_nextState = ST_IDLE;
          end else if (GAP_CYCLES > 0) begin
            w_nextState = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (w_gapDone) begin
          w_nextState = ST_SEND;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // State-decoded outputs.
  always_comb begin
    o_busy     = r_state != ST_IDLE;
    o_wr_ready = r_state == ST_LOAD;
  end

  // The output register is refilled on the first SEND cycle, straight after an
  // acceptance when there is no gap (back-to-back), or on the last gap cycle.
  // The row being loaded is therefore one ahead of r_sendRow on a back-to-back refill.
  always_comb begin
    w_loadPkt = ((r_state == ST_SEND) &&
                 (!r_pktValid || (w_pktFire && !w_lastRow && (GAP_CYCLES == 0)))) ||
                ((r_state == ST_GAP) && w_gapDone);
    w_rowSel  = ((r_state == ST_SEND) && w_pktFire && !w_lastRow) ? r_sendRow + 1'b1 : r_sendRow;
    w_dest    = NODE_W'(PE_BASE + int'(w_rowSel));

    w_pktNext                              = '0;
    w_pktNext[WIDTH_payload +: ROUTE_W]    = w_route;
    w_pktNext[WIDTH_payload + RSV_OFF]     = 1'b0;
    w_pktNext[WIDTH_payload-1:0]           = r_mem[w_rowSel];
  end

  filter_mem_node_param_route_hdr #(
    .MESH_X (MESH_X)
  ) u_routeHdr (
    .i_src  (NODE_W'(NODE)),
    .i_dest (w_dest),
    .o_hdr  (w_route)
  );

  // Counters, flags and the packet output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loadCnt  <= '0;
      r_sendRow  <= '0;
      r_gapCnt   <= '0;
      r_loaded   <= 1'b0;
      r_addrErr  <= 1'b0;
      r_pktValid <= 1'b0;
      r_pktData  <= '0;
    end else begin
      // A new load invalidates the stored filters until it completes and streams out.
      if ((r_state == ST_IDLE) && i_load_start) begin
        r_loadCnt <= '0;
        r_loaded  <= 1'b0;
      end else if (w_wrFire) begin
        r_loadCnt <= r_loadCnt + 1'b1;
        if (!w_addrOk) begin
          r_addrErr <= 1'b1;
        end
      end

      if ((r_state == ST_SEND) && w_pktFire && w_lastRow) begin
        r_loaded <= 1'b1;
      end

      if (((r_state == ST_IDLE) || (r_state == ST_WAIT_DONE)) && (w_nextState == ST_SEND)) begin
        r_sendRow <= '0;
      end else if ((r_state == ST_SEND) && w_pktFire) begin
        r_sendRow <= w_lastRow ? '0 : r_sendRow + 1'b1;
      end

      if (r_state == ST_GAP) begin
        r_gapCnt <= r_gapCnt + 1'b1;
      end else begin
        r_gapCnt <= '0;
      end

      if (w_loadPkt) begin
        r_pktValid <= 1'b1;
        r_pktData  <= w_pktNext;
      end else if (w_pktFire) begin
        r_pktValid <= 1'b0;
      end
    end
  end

  // Filter storage is deliberately not reset; out-of-range words are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wrFire && w_addrOk) begin
      r_mem[ROW_W'(w_rowLin)][w_col * WIDTH_data +: WIDTH_data] <= i_wr_data;
    end
  end

  assign o_pkt_valid = r_pktValid;
  assign o_pkt_data  = r_pktData;
  assign o_addr_err  = r_addrErr;

endmodule
